// File: rtl/button_input_ctrl.sv
// Push-button capture: 2-flop sync, per-button debounce, W1C press flags, level irq.
// Define BTN_RELEASE_EDGE_EN to also capture release events in PENDING/MASK [N_BTN+3:4].
module button_input_ctrl #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             ce,
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Flag bits that physically exist; everything else stays tied to 0.
  function automatic logic [7:0] valid_bits();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < N_BTN; i++) begin
      v[i] = 1'b1;
`ifdef BTN_RELEASE_EDGE_EN
      if (i < 4) v[i+4] = 1'b1;
`endif
    end
    return v;
  endfunction

  localparam logic [7:0] VALID = valid_bits();

  logic [N_BTN-1:0]         sync_1;
  logic [N_BTN-1:0]         sync_s;
  logic [N_BTN-1:0]         lvl;
  logic [N_BTN-1:0]         lvl_d;
  logic [N_BTN-1:0][CW-1:0] cnt;
  logic [7:0]               pending;
  logic [7:0]               mask;
  logic [7:0]               ev_set;
  logic [7:0]               clr;
  logic                     wr_en;
  logic                     unused_data_bits;

  assign unused_data_bits = ^data_in[31:8];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_s <= '0;
      lvl    <= '0;
      lvl_d  <= '0;
      cnt    <= '0;
    end else begin
      sync_1 <= btn_in;
      sync_s <= sync_1;
      lvl_d  <= lvl;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_s[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          lvl[i] <= sync_s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    ev_set = '0;
    for (int i = 0; i < N_BTN; i++) begin
      ev_set[i] = lvl[i] & ~lvl_d[i];
`ifdef BTN_RELEASE_EDGE_EN
      if (i < 4) ev_set[i+4] = ~lvl[i] & lvl_d[i];
`endif
    end
  end

  assign wr_en = ce & wr;
  assign clr   = (wr_en && addr == 2'd1) ? data_in[7:0] : 8'h00;

  // New events are OR'd in after the clear so a same-cycle set wins.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= ((pending & ~clr) | ev_set) & VALID;
      if (wr_en && addr == 2'd2) mask <= data_in[7:0] & VALID;
      irq <= |(pending & mask);
    end
  end

  always_comb begin
    data_out = '0;
    if (ce && !wr && !rst) begin
      case (addr)
        2'd0:    data_out = {{(32-N_BTN){1'b0}}, lvl};
        2'd1:    data_out = {24'd0, pending};
        2'd2:    data_out = {24'd0, mask};
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: doc/button_input_ctrl.md
# button_input_ctrl

Input-capture peripheral for the MIPS microcontroller's push-buttons, between the raw `port_io[3:0]` pins and the processor's data bus and interrupt input. It synchronises and debounces each button and latches press events into write-1-to-clear pending flags. It raises a level interrupt when an unmasked flag is set. The CPU reads button levels and pending events and clears them through a small memory-mapped register window.

## Interface
- `N_BTN`, default 4: number of button inputs, 1..8.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a new level, 2..65535.
- `sys_clk  in  1`: system clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `btn_in  in  N_BTN`: raw button levels from the port pins; asynchronous; 1 = pressed.
- `ce  in  1`: register-window chip enable from the address decoder.
- `wr  in  1`: 1 = write, 0 = read; qualified by `ce`.
- `addr  in  2`: register select, as a word index.
- `data_in  in  32`: write data.
- `data_out  out  32`: read data.
- `irq  out  1`: registered interrupt request; level-sensitive.

## Operation
- **Input path per button**
  - A 2-flop synchroniser produces `s`.
  - A debounced level `lvl` and a counter `cnt` track `s`.
  - If `s == lvl`, `cnt <= 0`.
  - Otherwise `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and `s != lvl`: `lvl <= s`, `cnt <= 0`.
  - Any return of `s` to `lvl` before that point restarts the count, so the glitch is ignored.
- **Edge detect:** `rise = lvl & ~lvl_d`, where `lvl_d` is `lvl` delayed one cycle. On `rise`, `pending[i] <= 1`.
- **Registers**
  - Addr 0, STATE (RO): bits [N_BTN-1:0] = `lvl`; other bits 0.
  - Addr 1, PENDING (W1C): bits [7:0] pending flags. Writing 1 clears a bit; writing 0 has no effect.
  - Addr 2, MASK (RW): bits [7:0]. A bit set to 1 enables `irq` for the matching pending bit.
  - Addr 3: reserved. Reads 0; writes ignored.
- **Read data:** `data_out` is combinational from `addr` when `ce & ~wr`; otherwise 0.
- **IRQ:** `irq <= |(pending & mask)`, registered.
- **Simultaneous events:** if a rise and a W1C clear of the same bit occur in the same cycle, the set wins and the bit stays 1.
- **Bit ranges:** bits at or above `N_BTN` in PENDING and MASK are tied 0.
- **Reset values:** synchronisers, `lvl`, `lvl_d`, `cnt`, `pending`, `mask` and `irq` all reset to 0. `data_out` is 0 under reset.
- **Reset mid-debounce:** the count is discarded. After release, a held button is re-accepted after a full latency and produces a fresh pending event, because `lvl` restarts at 0.

## Timing
- Raw change sampled at edge 0:
  - `s` changes after edge 2.
  - `lvl` changes after edge 2+DEBOUNCE_CYCLES.
  - `pending` sets one edge later.
  - `irq` asserts one edge after that.
- With default parameters, press-to-`irq` latency is 8 cycles.
- A press must be held at least DEBOUNCE_CYCLES+1 clock periods to be guaranteed capture.
- With defaults at a 20 ns period, a 100 ns pulse (5 cycles) is accepted.
- W1C write at edge k: the flag is clear after edge k; `irq` deasserts after edge k+1 if nothing else is pending.
- Clearing MASK deasserts `irq` one edge after the write.

## Configuration
- `BTN_RELEASE_EDGE_EN` defined:
  - Falling edges of `lvl` also set flags, in PENDING bits [N_BTN+3:4]. Requires `N_BTN <= 4`.
  - MASK bits [N_BTN+3:4] gate those flags into `irq`.
- Undefined:
  - Only press events are captured.
  - PENDING/MASK bits [7:4] read 0; writes to them are ignored.

## Test plan
- **Reset:** reset asserted -> `data_out`, `irq` = 0; STATE=0, PENDING=0, MASK=0 after deassert.
- **Single press:** `btn_in=4'b1000` for 5 cycles, MASK=0xF -> STATE bit3 =1 exactly 6 cycles after sampling, PENDING=0x8, `irq`=1 at cycle 8; `btn_in` back to 0 -> STATE returns 0, PENDING stays 0x8.
- **Glitch rejection:** `btn_in=4'b0100` for 3 cycles -> STATE, PENDING and `irq` never change.
- **W1C:** PENDING=0x3; write 0x1 to addr 1 -> PENDING=0x2, `irq` stays 1; write 0x2 -> PENDING=0, `irq`=0 one cycle later.
- **Set/clear collision:** W1C of bit 1 in the same cycle as its rise -> PENDING bit1 remains 1.
- **Mask and macro:** MASK=0, press button 0 -> PENDING=0x1, `irq`=0; write MASK=0x1 -> `irq`=1 next cycle. With `BTN_RELEASE_EDGE_EN`, releasing button 0 -> PENDING bit4 =1; without it, bit4 stays 0.
